// File: rtl/pipe_pkg.sv
// Shared constants for the elastic inter-stage registers: control bit positions, default widths,
// and the width of the payload that travels alongside the control bundle.
package pipe_pkg;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_CTRL_W  = 4;
   localparam int DEF_REG_W   = 5;
   localparam int DEF_INSTR_W = 32;
   localparam int DEF_CNT_W   = 16;

   // Data + Aux + RdReg + Instruction; ctrl is stored separately so a flush can clear it alone.
   function automatic int payload_w(input int data_w, input int reg_w, input int instr_w);
      return 2 * data_w + reg_w + instr_w;
   endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid + ctrl + payload slot; clear drops the beat and zeroes ctrl, keep_data_i decides
// whether the payload survives the clear. Clear wins over load; no handshake of its own.
module pipe_stage_entry #(
   parameter int CTRL_W = 4,
   parameter int PAY_W  = 74
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic              keep_data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [PAY_W-1:0]  pay_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [PAY_W-1:0]  pay_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [PAY_W-1:0]  pay_q, pay_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pay_d   = pay_q;
      if (clear_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (!keep_data_i) begin
            pay_d = '0;
         end
      end else if (load_i) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         pay_d   = pay_i;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pay_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pay_q   <= pay_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign pay_o   = pay_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid (M drives outputs, S catches the in-flight beat);
// 1-cycle latency, 1 beat/cycle, In_Ready is registered (!S.valid) and never sees Out_Ready.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_W             = DEF_DATA_W,
   parameter int CTRL_W             = DEF_CTRL_W,
   parameter int REG_W              = DEF_REG_W,
   parameter int INSTR_W            = DEF_INSTR_W,
   parameter int KEEP_DATA_ON_FLUSH = 0,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               In_Valid,
   output logic               In_Ready,
   input  logic               In_Flush,
   input  logic [CTRL_W-1:0]  In_Ctrl,
   input  logic [DATA_W-1:0]  In_Data,
   input  logic [DATA_W-1:0]  In_Aux,
   input  logic [REG_W-1:0]   In_RdReg,
   input  logic [INSTR_W-1:0] In_Instruction,
   output logic               Out_Valid,
   input  logic               Out_Ready,
   output logic [CTRL_W-1:0]  Out_Ctrl,
   output logic [DATA_W-1:0]  Out_Data,
   output logic [DATA_W-1:0]  Out_Aux,
   output logic [REG_W-1:0]   Out_RdReg,
   output logic [INSTR_W-1:0] Out_Instruction,
   output logic [CNT_W-1:0]   StallCount
);

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [DATA_W-1:0]  aux;
      logic [REG_W-1:0]   rd;
      logic [INSTR_W-1:0] instr;
   } pay_t;

   localparam int   PAY_W = payload_w(DATA_W, REG_W, INSTR_W);
   localparam logic KEEP  = (KEEP_DATA_ON_FLUSH != 0);

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_src;
   pay_t              m_pay, s_pay, m_pay_src, in_pay;
   logic              accept, release_beat;
   logic              m_load, m_clear, m_keep, s_load, s_clear, s_keep;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign in_pay       = '{data: In_Data, aux: In_Aux, rd: In_RdReg, instr: In_Instruction};
   assign accept       = In_Valid & ~s_valid;
   assign release_beat = m_valid & Out_Ready;

   // A full S always refills M first, so accept can only land in M when S is empty.
   assign m_ctrl_src = s_valid ? s_ctrl : In_Ctrl;
   assign m_pay_src  = s_valid ? s_pay  : in_pay;

   always_comb begin
      m_load  = 1'b0;
      m_clear = 1'b0;
      m_keep  = 1'b1;
      s_load  = 1'b0;
      s_clear = 1'b0;
      s_keep  = 1'b1;
      if (In_Flush) begin
         m_clear = 1'b1;
         m_keep  = KEEP;
         s_clear = 1'b1;
         s_keep  = KEEP;
      end else begin
         m_load  = (release_beat & s_valid) | (accept & (~m_valid | release_beat));
         m_clear = release_beat & ~s_valid & ~accept;
         s_load  = accept & m_valid & ~release_beat;
         s_clear = release_beat & s_valid;
      end
   end

   pipe_stage_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_m (
      .Clock       (Clock),
      .Reset       (Reset),
      .load_i      (m_load),
      .clear_i     (m_clear),
      .keep_data_i (m_keep),
      .ctrl_i      (m_ctrl_src),
      .pay_i       (m_pay_src),
      .valid_o     (m_valid),
      .ctrl_o      (m_ctrl),
      .pay_o       (m_pay)
   );

   pipe_stage_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_s (
      .Clock       (Clock),
      .Reset       (Reset),
      .load_i      (s_load),
      .clear_i     (s_clear),
      .keep_data_i (s_keep),
      .ctrl_i      (In_Ctrl),
      .pay_i       (in_pay),
      .valid_o     (s_valid),
      .ctrl_o      (s_ctrl),
      .pay_o       (s_pay)
   );

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (m_valid && !Out_Ready && stall_cnt_q != {CNT_W{1'b1}}) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign In_Ready        = ~s_valid;
   assign Out_Valid       = m_valid;
   assign Out_Ctrl        = m_valid ? m_ctrl : '0;
   assign Out_Data        = m_pay.data;
   assign Out_Aux         = m_pay.aux;
   assign Out_RdReg       = m_pay.rd;
   assign Out_Instruction = m_pay.instr;
   assign StallCount      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Two instances share one stimulus stream: A zeroes payload on flush with a 16-bit counter,
// B keeps payload with a 4-bit counter. A FIFO-queue model supplies expected outputs.
module tb_pipe_stage_elastic;

   logic        Clock;
   logic        Reset;
   logic        In_Valid;
   logic        In_Flush;
   logic [3:0]  In_Ctrl;
   logic [31:0] In_Data;
   logic [31:0] In_Aux;
   logic [4:0]  In_RdReg;
   logic [31:0] In_Instruction;
   logic        Out_Ready;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [3:0]  a_ctrl, b_ctrl;
   logic [31:0] a_data, a_aux, a_instr, b_data, b_aux, b_instr;
   logic [4:0]  a_rd, b_rd;
   logic [15:0] a_stall;
   logic [3:0]  b_stall;

   pipe_stage_elastic #(.KEEP_DATA_ON_FLUSH(0), .CNT_W(16)) dut_a (
      .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(a_in_ready),
      .In_Flush(In_Flush), .In_Ctrl(In_Ctrl), .In_Data(In_Data), .In_Aux(In_Aux),
      .In_RdReg(In_RdReg), .In_Instruction(In_Instruction), .Out_Valid(a_out_valid),
      .Out_Ready(Out_Ready), .Out_Ctrl(a_ctrl), .Out_Data(a_data), .Out_Aux(a_aux),
      .Out_RdReg(a_rd), .Out_Instruction(a_instr), .StallCount(a_stall)
   );

   pipe_stage_elastic #(.KEEP_DATA_ON_FLUSH(1), .CNT_W(4)) dut_b (
      .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(b_in_ready),
      .In_Flush(In_Flush), .In_Ctrl(In_Ctrl), .In_Data(In_Data), .In_Aux(In_Aux),
      .In_RdReg(In_RdReg), .In_Instruction(In_Instruction), .Out_Valid(b_out_valid),
      .Out_Ready(Out_Ready), .Out_Ctrl(b_ctrl), .Out_Data(b_data), .Out_Aux(b_aux),
      .Out_RdReg(b_rd), .Out_Instruction(b_instr), .StallCount(b_stall)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] data;
      logic [31:0] aux;
      logic [4:0]  rd;
      logic [31:0] instr;
   } beat_t;

   typedef struct {
      bit          vld;
      logic [31:0] dat;
      bit          ordy;
      bit          fl;
      bit          e_ovld;
      logic [31:0] e_odat;
      bit          e_irdy;
      int          e_cnt;
   } vec_t;

   beat_t q[$];
   int    cnt_a;
   int    cnt_b;
   int    total;
   int    bad;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit vld, input logic [31:0] dat, input bit ordy, input bit fl);
      In_Valid       = vld;
      In_Data        = dat;
      In_Ctrl        = dat[3:0];
      In_Aux         = ~dat;
      In_RdReg       = dat[4:0];
      In_Instruction = {dat[15:0], ~dat[15:0]};
      Out_Ready      = ordy;
      In_Flush       = fl;
   endtask

   task automatic check_model();
      chk("a_in_ready", a_in_ready, q.size() < 2);
      chk("b_in_ready", b_in_ready, q.size() < 2);
      chk("a_out_valid", a_out_valid, q.size() > 0);
      chk("b_out_valid", b_out_valid, q.size() > 0);
      chk("a_stall", a_stall, cnt_a);
      chk("b_stall", b_stall, cnt_b);
      if (q.size() > 0) begin
         chk("a_ctrl", a_ctrl, q[0].ctrl);
         chk("a_data", a_data, q[0].data);
         chk("a_aux", a_aux, q[0].aux);
         chk("a_rd", a_rd, q[0].rd);
         chk("a_instr", a_instr, q[0].instr);
         chk("b_ctrl", b_ctrl, q[0].ctrl);
         chk("b_data", b_data, q[0].data);
         chk("b_instr", b_instr, q[0].instr);
      end else begin
         chk("a_bubble_ctrl", a_ctrl, 0);
         chk("b_bubble_ctrl", b_ctrl, 0);
      end
   endtask

   // Advance one clock; the model sees the same pre-edge inputs and occupancy as the DUTs.
   task automatic tick();
      beat_t nb;
      bit    acc, rel, stl, rst, fl;
      acc = In_Valid && (q.size() < 2);
      rel = (q.size() > 0) && Out_Ready;
      stl = (q.size() > 0) && !Out_Ready;
      rst = Reset;
      fl  = In_Flush;
      nb  = '{ctrl: In_Ctrl, data: In_Data, aux: In_Aux, rd: In_RdReg, instr: In_Instruction};
      @(posedge Clock);
      #1;
      if (rst) begin
         q.delete();
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         if (stl) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 15) cnt_b++;
         end
         if (fl) begin
            q.delete();
         end else begin
            if (rel) void'(q.pop_front());
            if (acc) q.push_back(nb);
         end
      end
      check_model();
   endtask

   function automatic vec_t mk(input bit vld, input logic [31:0] dat, input bit ordy,
                               input bit e_ovld, input logic [31:0] e_odat, input bit e_irdy,
                               input int e_cnt);
      vec_t v;
      v.vld = vld; v.dat = dat; v.ordy = ordy; v.fl = 1'b0;
      v.e_ovld = e_ovld; v.e_odat = e_odat; v.e_irdy = e_irdy; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      total = 0;
      bad   = 0;
      cnt_a = 0;
      cnt_b = 0;

      for (int i = 0; i < 8; i++) begin
         tbl[i] = mk(1'b1, 32'(i + 1), 1'b1, 1'b1, 32'(i + 1), 1'b1, 0);
      end
      tbl[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 0);
      tbl[9]  = mk(1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 0);
      tbl[10] = mk(1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 1);
      tbl[11] = mk(1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 2);
      tbl[12] = mk(1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 3);
      tbl[13] = mk(1'b1, 32'h33, 1'b1, 1'b1, 32'h22, 1'b1, 3);
      tbl[14] = mk(1'b1, 32'h33, 1'b1, 1'b1, 32'h33, 1'b1, 3);
      tbl[15] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 3);

      // Reset held two cycles with a live, all-ones control beat on the input.
      Reset = 1'b1;
      drive(1'b1, 32'hF, 1'b0, 1'b0);
      In_Ctrl = 4'hF;
      tick();
      tick();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_ctrl", a_ctrl, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_in_ready", a_in_ready, 1);
      Reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("post_rst_out_valid", a_out_valid, 0);
      chk("post_rst_in_ready", a_in_ready, 1);
      chk("post_rst_data", a_data, 0);

      // Streaming then back-pressure with skid, constant expectations.
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].vld, tbl[i].dat, tbl[i].ordy, tbl[i].fl);
         tick();
         chk($sformatf("tbl%0d_ovld", i), a_out_valid, tbl[i].e_ovld);
         if (tbl[i].e_ovld) chk($sformatf("tbl%0d_odat", i), a_data, tbl[i].e_odat);
         chk($sformatf("tbl%0d_irdy", i), a_in_ready, tbl[i].e_irdy);
         chk($sformatf("tbl%0d_cnt", i), a_stall, tbl[i].e_cnt);
      end

      // Flush with both entries full and a competing input beat.
      drive(1'b1, 32'h55, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h66, 1'b0, 1'b0);
      tick();
      chk("pre_flush_irdy", a_in_ready, 0);
      drive(1'b1, 32'h44, 1'b0, 1'b1);
      tick();
      chk("flush_a_ovld", a_out_valid, 0);
      chk("flush_a_ctrl", a_ctrl, 0);
      chk("flush_a_data", a_data, 0);
      chk("flush_a_rd", a_rd, 0);
      chk("flush_a_irdy", a_in_ready, 1);
      chk("flush_a_stall", a_stall, 5);
      chk("flush_b_ovld", b_out_valid, 0);
      chk("flush_b_ctrl", b_ctrl, 0);
      chk("flush_b_data", b_data, 32'h55);
      chk("flush_b_stall", b_stall, 5);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();
      chk("post_flush_a_ovld", a_out_valid, 0);
      chk("post_flush_b_data", b_data, 32'h55);

      // Counter saturation on the 4-bit instance.
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      drive(1'b1, 32'h77, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (20) tick();
      chk("sat_b", b_stall, 15);
      chk("sat_a", a_stall, 20);
      repeat (3) tick();
      chk("sat_b_hold", b_stall, 15);
      chk("sat_a_more", a_stall, 23);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         Reset = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 39) == 0);
         tick();
      end
      Reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries the control bundle, two data words, the destination register and the debug instruction between adjacent stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so In_Ready comes from a flop and never depends combinationally on Out_Ready.
- Supports flush with bubble insertion, optional data retention on flush, and a saturating back-pressure counter for debug.

Parameters:
DATA_W, 32, width of Data and Aux payload words (ALU result / Rt data)
CTRL_W, 4, width of control bundle (bit indices from pipe_pkg)
REG_W, 5, destination register index width
INSTR_W, 32, debug instruction width
KEEP_DATA_ON_FLUSH, 0, 1 = flush clears only valid+ctrl; 0 = flush also zeroes Data/Aux/RdReg/Instruction
CNT_W, 16, stall counter width

Ports:
Clock  in  1  processor clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
In_Valid  in  1  upstream beat valid
In_Ready  out  1  block can accept a beat (registered)
In_Flush  in  1  synchronous flush of all held beats
In_Ctrl  in  CTRL_W  control bundle
In_Data  in  DATA_W  primary data word
In_Aux  in  DATA_W  secondary data word
In_RdReg  in  REG_W  destination register
In_Instruction  in  INSTR_W  debug instruction
Out_Valid  out  1  downstream beat valid
Out_Ready  in  1  downstream accepts beat
Out_Ctrl  out  CTRL_W  control bundle, forced 0 when Out_Valid=0
Out_Data  out  DATA_W  primary data
Out_Aux  out  DATA_W  secondary data
Out_RdReg  out  REG_W  destination register
Out_Instruction  out  INSTR_W  debug instruction
StallCount  out  CNT_W  cycles with Out_Valid=1 and Out_Ready=0, saturating

Behaviour:
- Reset (sync, high): both entries invalid, all payload 0, StallCount=0. In the cycle after reset: Out_Valid=0, Out_Ctrl=0, In_Ready=1. In_Valid is ignored while Reset=1.
- Storage: main entry M (drives outputs) and skid entry S. In_Ready = !S.valid, taken from the flop.
- Handshake: accept = In_Valid & In_Ready; release = Out_Valid & Out_Ready. Out_Valid = M.valid.
- Latency: 1 cycle from accept into empty block to Out_Valid. Throughput 1 beat/cycle while Out_Ready=1.
- Update rules, evaluated at posedge, with flush and reset absent:
  - M empty and accept: M <= input.
  - M full, release, S empty, accept: M <= input.
  - M full, release, S full: M <= S; S <= invalid. accept is impossible here because In_Ready=0.
  - M full, no release, accept: S <= input, so In_Ready=0 next cycle.
  - M full, release, no accept, S empty: M <= invalid.
- Ordering is strict FIFO. A beat is never duplicated or dropped without a flush.
- Flush priority is Reset > In_Flush > handshake.
  - In_Flush=1: M and S become invalid and their ctrl fields 0. Payload is zeroed when KEEP_DATA_ON_FLUSH=0 and held otherwise.
  - The input beat presented in the flush cycle is discarded, even if accept would be true.
  - A release in the flush cycle still counts as consumed downstream.
- Out_Ctrl/Out_RdReg in bubbles: Out_Ctrl=0 whenever Out_Valid=0, so no spurious RegWrite/MemWrite. Out_RdReg=0 after a zeroing flush.
- StallCount: increments when Out_Valid & !Out_Ready, saturates at 2^CNT_W-1, holds otherwise. Cleared only by Reset; flush does not clear it.
- Reset mid-operation discards both entries in the same cycle; there is no partial drain.

Decomposition:
- pipe_pkg: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, default widths, and a payload struct/concat width helper.
- Sub-module pipe_stage_entry: one valid + payload register with load, clear and keep-data controls, instantiated twice (M, S). The top level holds the steering logic and the counter.

Test Plan:
- Reset: hold Reset 2 cycles with In_Valid=1, In_Ctrl=4'hF → Out_Valid=0, Out_Ctrl=0, StallCount=0, In_Ready=1 in the cycle after release.
- Streaming: Out_Ready=1, present Data=1..8 back-to-back → Out_Data=1..8 on consecutive cycles, 1-cycle latency, In_Ready stays 1.
- Back-pressure: Out_Ready=0 while sending A=0x11, B=0x22, C=0x33 → In_Ready drops after B is skidded; C is held upstream; StallCount increments each stalled cycle. Raising Out_Ready gives output order 0x11, 0x22, 0x33.
- Flush with KEEP=0: M and S full, In_Flush=1 with In_Valid=1, Data=0x44 → next cycle Out_Valid=0, Out_Ctrl=0, Out_Data=0, In_Ready=1; 0x44 never appears at the output.
- Flush with KEEP=1: same stimulus → Out_Valid=0, Out_Ctrl=0, Out_Data retains the old value; StallCount unchanged by the flush.
- Saturation: CNT_W=4, stall for 20 cycles → StallCount=15 and holds at 15.
